// File: rtl/spi_veri_yolu_koprusu.sv
// Load/store bridge between the core memory stage and the SPI controller
// register port. Decodes the 32-byte SPI window, rejects illegal accesses
// locally, issues one single-cycle pulse per attempt and retries while the
// controller is stalled by its shift engine. One access outstanding at a time.
//
// state      | meaning
// -----------+---------------------------------------------------------------
// BOSTA      | idle, request port ready, latches and checks incoming access
// VER        | issue pulse to SPI with latched fields, attempt counter +1
// BEKLE      | wait one cycle for completion; retry, time out or respond
// HATA_YANIT | illegal access, prepare error response without touching SPI
// YANIT      | response valid, held until the core accepts it
module spi_veri_yolu_koprusu #(
   parameter logic [31:0] TABAN_ADRES   = 32'h2001_0000,
   parameter int          DENEME_SINIRI = 16
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        istek_gecerli_i,
   output logic        istek_hazir_o,
   input  logic        istek_yaz_i,
   input  logic [31:0] istek_adres_i,
   input  logic [1:0]  istek_boyut_i,
   input  logic [31:0] istek_veri_i,
   output logic        yanit_gecerli_o,
   input  logic        yanit_hazir_i,
   output logic [31:0] yanit_veri_o,
   output logic        yanit_hata_o,
   output logic [4:0]  adres_bit_o,
   output logic        islem_o,
   output logic        islem_gecerli_o,
   output logic [1:0]  read_type_o,
   output logic [1:0]  write_type_o,
   output logic [31:0] veri_o,
   input  logic        islem_bitti_i,
   input  logic [31:0] veri_i
);

   localparam int SW = $clog2(DENEME_SINIRI + 1);

   typedef enum logic [2:0] {
      BOSTA,
      VER,
      BEKLE,
      HATA_YANIT,
      YANIT
   } durum_t;

   durum_t        durum_q, durum_d;
   logic [SW-1:0] sayac_q;
   logic          sayac_arttir, sayac_sifirla;
   logic          yakala;
   logic [4:0]    adres_q;
   logic          yaz_q;
   logic [1:0]    boyut_q;
   logic [31:0]   veri_q;
   logic [31:0]   yanit_veri_q, yanit_veri_d;
   logic          yanit_hata_q, yanit_hata_d;

   logic [31:0]   ofset;
   logic          pencere_ici;
   logic          hizasiz;
   logic          yasak;

   // Access legality, evaluated on the raw request while idle. The window
   // test uses a wrapping subtraction so addresses below the base fall out.
   always_comb begin
      ofset       = istek_adres_i - TABAN_ADRES;
      pencere_ici = (ofset < 32'd32);
      hizasiz     = ((istek_boyut_i == 2'b01) && istek_adres_i[0]) ||
                    ((istek_boyut_i == 2'b10) && (istek_adres_i[1:0] != 2'b00));
      // WDATA (offset 0x0c) is write-only; a load there would never complete.
      yasak       = !pencere_ici || (istek_boyut_i == 2'b11) || hizasiz ||
                    (!istek_yaz_i && (istek_adres_i[4:0] == 5'h0c));
   end

   // State register.
   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) durum_q <= BOSTA;
      else        durum_q <= durum_d;
   end

   // Next-state and handshake outputs.
   always_comb begin
      durum_d         = durum_q;
      istek_hazir_o   = 1'b0;
      islem_gecerli_o = 1'b0;
      yanit_gecerli_o = 1'b0;
      yakala          = 1'b0;
      sayac_arttir    = 1'b0;
      sayac_sifirla   = 1'b0;
      yanit_veri_d    = yanit_veri_q;
      yanit_hata_d    = yanit_hata_q;
      case (durum_q)
         BOSTA: begin
            istek_hazir_o = 1'b1;
            if (istek_gecerli_i) begin
               yakala  = 1'b1;
               durum_d = yasak ? HATA_YANIT : VER;
            end
         end
         VER: begin
            islem_gecerli_o = 1'b1;
            sayac_arttir    = 1'b1;
            durum_d         = BEKLE;
         end
         BEKLE: begin
            if (islem_bitti_i) begin
               yanit_veri_d = yaz_q ? 32'h0 : veri_i;
               yanit_hata_d = 1'b0;
               durum_d      = YANIT;
            end else if (sayac_q == SW'(DENEME_SINIRI)) begin
               yanit_veri_d = 32'h0;
               yanit_hata_d = 1'b1;
               durum_d      = YANIT;
            end else begin
               durum_d = VER;
            end
         end
         HATA_YANIT: begin
            yanit_veri_d = 32'h0;
            yanit_hata_d = 1'b1;
            durum_d      = YANIT;
         end
         YANIT: begin
            yanit_gecerli_o = 1'b1;
            if (yanit_hazir_i) begin
               sayac_sifirla = 1'b1;
               yanit_veri_d  = 32'h0;
               yanit_hata_d  = 1'b0;
               durum_d       = BOSTA;
            end
         end
         default: durum_d = BOSTA;
      endcase
   end

   // Attempt counter, cleared once the response has been consumed.
   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i)             sayac_q <= '0;
      else if (sayac_sifirla) sayac_q <= '0;
      else if (sayac_arttir)  sayac_q <= sayac_q + 1'b1;
   end

   // Request fields captured on acceptance and replayed on every retry.
   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         adres_q <= '0;
         yaz_q   <= 1'b0;
         boyut_q <= '0;
         veri_q  <= '0;
      end else if (yakala) begin
         adres_q <= istek_adres_i[4:0];
         yaz_q   <= istek_yaz_i;
         boyut_q <= istek_boyut_i;
         veri_q  <= istek_yaz_i ? istek_veri_i : 32'h0;
      end
   end

   // Response buffer, stable for the whole time the response is offered.
   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         yanit_veri_q <= '0;
         yanit_hata_q <= 1'b0;
      end else begin
         yanit_veri_q <= yanit_veri_d;
         yanit_hata_q <= yanit_hata_d;
      end
   end

   // SPI-side fields; the size goes only to the port matching the direction.
   always_comb begin
      adres_bit_o  = adres_q;
      islem_o      = yaz_q;
      read_type_o  = yaz_q ? 2'b00 : boyut_q;
      write_type_o = yaz_q ? boyut_q : 2'b00;
      veri_o       = veri_q;
      yanit_veri_o = yanit_veri_q;
      yanit_hata_o = yanit_hata_q;
   end

endmodule

// File: tb/tb_spi_veri_yolu_koprusu.sv
// Directed bench for the SPI bridge with a small SPI responder model.
module tb_spi_veri_yolu_koprusu;

   localparam logic [31:0] TABAN = 32'h2001_0000;

   logic        clk_i = 1'b0;
   logic        rst_i;
   logic        istek_gecerli_i, istek_hazir_o, istek_yaz_i;
   logic [31:0] istek_adres_i, istek_veri_i;
   logic [1:0]  istek_boyut_i;
   logic        yanit_gecerli_o, yanit_hazir_i, yanit_hata_o;
   logic [31:0] yanit_veri_o;
   logic [4:0]  adres_bit_o;
   logic        islem_o, islem_gecerli_o;
   logic [1:0]  read_type_o, write_type_o;
   logic [31:0] veri_o;
   logic        islem_bitti_i;
   logic [31:0] veri_i;

   int toplam  = 0;
   int hatalar = 0;

   // responder model state
   int          darbe_sayisi = 0;
   int          esik         = 1000;
   int          ardisik      = 0;
   logic        gorulen      = 1'b0;
   logic [31:0] model_veri   = 32'h0;
   logic [4:0]  yak_adres    = '0;
   logic [1:0]  yak_wt       = '0;
   logic [1:0]  yak_rt       = '0;
   logic        yak_islem    = 1'b0;
   logic [31:0] yak_veri     = '0;

   spi_veri_yolu_koprusu dut (
      .clk_i           (clk_i),
      .rst_i           (rst_i),
      .istek_gecerli_i (istek_gecerli_i),
      .istek_hazir_o   (istek_hazir_o),
      .istek_yaz_i     (istek_yaz_i),
      .istek_adres_i   (istek_adres_i),
      .istek_boyut_i   (istek_boyut_i),
      .istek_veri_i    (istek_veri_i),
      .yanit_gecerli_o (yanit_gecerli_o),
      .yanit_hazir_i   (yanit_hazir_i),
      .yanit_veri_o    (yanit_veri_o),
      .yanit_hata_o    (yanit_hata_o),
      .adres_bit_o     (adres_bit_o),
      .islem_o         (islem_o),
      .islem_gecerli_o (islem_gecerli_o),
      .read_type_o     (read_type_o),
      .write_type_o    (write_type_o),
      .veri_o          (veri_o),
      .islem_bitti_i   (islem_bitti_i),
      .veri_i          (veri_i)
   );

   always #5 clk_i = ~clk_i;

   // Record issue pulses, the fields they carry, and back-to-back pulses.
   always @(posedge clk_i) begin
      gorulen <= islem_gecerli_o;
      if (islem_gecerli_o) begin
         darbe_sayisi <= darbe_sayisi + 1;
         yak_adres    <= adres_bit_o;
         yak_wt       <= write_type_o;
         yak_rt       <= read_type_o;
         yak_islem    <= islem_o;
         yak_veri     <= veri_o;
         if (gorulen) ardisik <= ardisik + 1;
      end
   end

   // Complete one cycle after a pulse, but only once more than esik pulses seen.
   always @(negedge clk_i) begin
      if (gorulen && (darbe_sayisi > esik)) begin
         islem_bitti_i = 1'b1;
         veri_i        = model_veri;
      end else begin
         islem_bitti_i = 1'b0;
         veri_i        = 32'hDEAD_BEEF;
      end
   end

   task automatic kontrol(input string ad, input logic [31:0] gozlenen, input logic [31:0] beklenen);
      toplam++;
      assert (gozlenen === beklenen)
      else begin
         hatalar++;
         $error("FAIL %s: observed=%h expected=%h", ad, gozlenen, beklenen);
      end
   endtask

   task automatic islem(input string ad, input logic yaz, input logic [31:0] adres,
                        input logic [1:0] boyut, input logic [31:0] veri, input int durdur,
                        input int bek_dongu, input logic bek_hata, input logic [31:0] bek_veri,
                        input int bek_darbe, input int tutma);
      int          baz;
      int          n;
      logic        bulundu;
      logic [31:0] v;
      logic        h;
      @(negedge clk_i);
      esik = darbe_sayisi + durdur;
      baz  = darbe_sayisi;
      kontrol({ad, "_hazir"}, 32'(istek_hazir_o), 32'd1);
      istek_gecerli_i = 1'b1;
      istek_yaz_i     = yaz;
      istek_adres_i   = adres;
      istek_boyut_i   = boyut;
      istek_veri_i    = veri;
      @(posedge clk_i);
      n       = 0;
      bulundu = 1'b0;
      while (!bulundu && n < 60) begin
         @(negedge clk_i);
         n++;
         istek_gecerli_i = 1'b0;
         if (yanit_gecerli_o) bulundu = 1'b1;
      end
      kontrol({ad, "_yanit_var"}, 32'(bulundu), 32'd1);
      kontrol({ad, "_dongu"}, 32'(n), 32'(bek_dongu));
      kontrol({ad, "_hata"}, 32'(yanit_hata_o), 32'(bek_hata));
      kontrol({ad, "_veri"}, yanit_veri_o, bek_veri);
      kontrol({ad, "_darbe"}, 32'(darbe_sayisi - baz), 32'(bek_darbe));
      v = yanit_veri_o;
      h = yanit_hata_o;
      for (int i = 0; i < tutma; i++) begin
         @(negedge clk_i);
         kontrol({ad, "_tut_gecerli"}, 32'(yanit_gecerli_o), 32'd1);
         kontrol({ad, "_tut_veri"}, yanit_veri_o, v);
         kontrol({ad, "_tut_hata"}, 32'(yanit_hata_o), 32'(h));
         kontrol({ad, "_tut_istek_hazir"}, 32'(istek_hazir_o), 32'd0);
      end
      yanit_hazir_i = 1'b1;
      @(negedge clk_i);
      yanit_hazir_i = 1'b0;
      kontrol({ad, "_sonra_gecerli"}, 32'(yanit_gecerli_o), 32'd0);
      kontrol({ad, "_sonra_istek_hazir"}, 32'(istek_hazir_o), 32'd1);
   endtask

   initial begin
      rst_i           = 1'b0;
      istek_gecerli_i = 1'b0;
      istek_yaz_i     = 1'b0;
      istek_adres_i   = 32'h0;
      istek_boyut_i   = 2'b00;
      istek_veri_i    = 32'h0;
      yanit_hazir_i   = 1'b0;
      #3;
      kontrol("rst_islem_gecerli", 32'(islem_gecerli_o), 32'd0);
      kontrol("rst_yanit_gecerli", 32'(yanit_gecerli_o), 32'd0);
      kontrol("rst_yanit_hata", 32'(yanit_hata_o), 32'd0);
      kontrol("rst_yanit_veri", yanit_veri_o, 32'h0);
      kontrol("rst_veri_o", veri_o, 32'h0);
      kontrol("rst_istek_hazir", 32'(istek_hazir_o), 32'd1);
      @(negedge clk_i);
      rst_i = 1'b1;

      // word store at +0x00
      islem("yaz_kelime", 1'b1, TABAN, 2'b10, 32'h0001_0009, 0, 3, 1'b0, 32'h0, 1, 0);
      kontrol("yaz_kelime_adres", 32'(yak_adres), 32'd0);
      kontrol("yaz_kelime_wt", 32'(yak_wt), 32'd2);
      kontrol("yaz_kelime_islem", 32'(yak_islem), 32'd1);
      kontrol("yaz_kelime_spi_veri", yak_veri, 32'h0001_0009);

      // word load at +0x04
      model_veri = 32'h0000_002A;
      islem("oku_kelime", 1'b0, TABAN + 32'h4, 2'b10, 32'hFFFF_FFFF, 0, 3, 1'b0, 32'h2A, 1, 0);
      kontrol("oku_kelime_adres", 32'(yak_adres), 32'd4);
      kontrol("oku_kelime_rt", 32'(yak_rt), 32'd2);
      kontrol("oku_kelime_islem", 32'(yak_islem), 32'd0);

      // three stalled attempts, fourth completes
      model_veri = 32'hCAFE_0123;
      islem("durdur3", 1'b0, TABAN + 32'h8, 2'b10, 32'h0, 3, 9, 1'b0, 32'hCAFE_0123, 4, 0);

      // never completes: 16 attempts then timeout
      islem("zaman_asimi", 1'b1, TABAN + 32'h10, 2'b01, 32'h1234, 1000, 33, 1'b1, 32'h0, 16, 0);

      // locally rejected accesses
      islem("oku_0c", 1'b0, TABAN + 32'hC, 2'b10, 32'h0, 0, 2, 1'b1, 32'h0, 0, 0);
      islem("yarim_hizasiz", 1'b0, TABAN + 32'h1, 2'b01, 32'h0, 0, 2, 1'b1, 32'h0, 0, 0);
      islem("pencere_disi", 1'b1, TABAN + 32'h20, 2'b10, 32'h5, 0, 2, 1'b1, 32'h0, 0, 0);
      islem("taban_alti", 1'b0, TABAN - 32'h4, 2'b10, 32'h0, 0, 2, 1'b1, 32'h0, 0, 0);
      islem("boyut_11", 1'b1, TABAN, 2'b11, 32'h5, 0, 2, 1'b1, 32'h0, 0, 0);

      // legal byte store at an odd offset, response held for 5 cycles
      model_veri = 32'h1234_5678;
      islem("bayt_yaz", 1'b1, TABAN + 32'h3, 2'b00, 32'h0000_00A5, 0, 3, 1'b0, 32'h0, 1, 0);
      islem("tut5", 1'b0, TABAN + 32'h4, 2'b10, 32'h0, 0, 3, 1'b0, 32'h1234_5678, 1, 5);

      // reset while waiting for completion
      @(negedge clk_i);
      esik            = darbe_sayisi + 1000;
      istek_gecerli_i = 1'b1;
      istek_yaz_i     = 1'b1;
      istek_adres_i   = TABAN + 32'h8;
      istek_boyut_i   = 2'b10;
      istek_veri_i    = 32'h0000_0055;
      @(posedge clk_i);
      @(negedge clk_i);
      istek_gecerli_i = 1'b0;
      kontrol("rst2_ver_darbe", 32'(islem_gecerli_o), 32'd1);
      @(negedge clk_i);
      kontrol("rst2_bekle_veri_o", veri_o, 32'h0000_0055);
      rst_i = 1'b0;
      #1;
      kontrol("rst2_islem_gecerli", 32'(islem_gecerli_o), 32'd0);
      kontrol("rst2_yanit_gecerli", 32'(yanit_gecerli_o), 32'd0);
      kontrol("rst2_yanit_hata", 32'(yanit_hata_o), 32'd0);
      kontrol("rst2_yanit_veri", yanit_veri_o, 32'h0);
      kontrol("rst2_veri_o", veri_o, 32'h0);
      kontrol("rst2_adres_bit", 32'(adres_bit_o), 32'd0);
      kontrol("rst2_islem", 32'(islem_o), 32'd0);
      kontrol("rst2_write_type", 32'(write_type_o), 32'd0);
      kontrol("rst2_istek_hazir", 32'(istek_hazir_o), 32'd1);
      @(negedge clk_i);
      rst_i = 1'b1;

      model_veri = 32'h0000_0077;
      islem("rst_sonrasi", 1'b0, TABAN + 32'h10, 2'b10, 32'h0, 0, 3, 1'b0, 32'h77, 1, 0);

      kontrol("ardisik_darbe", 32'(ardisik), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", toplam, hatalar);
      $finish;
   end

endmodule
